// File: rtl/la_rstseq_pkg.sv
// Shared definitions for the la_rstseq reset-release sequencer.
// State encoding and the stage-index width helper live here so the
// interface and the sequencer agree on them.
package la_rstseq_pkg;

  // 3-bit state encoding; StFail is only reachable with LA_RSTSEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCount   = 3'd1,
    StWaitRdy = 3'd2,
    StUp      = 3'd3,
    StDown    = 3'd4,
    StFail    = 3'd5
  } state_e;

  // Width of the stage index: clog2(n), but never narrower than one bit
  function automatic int unsigned stage_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/la_rstseq_if.sv
// Control/status bundle of the la_rstseq sequencer.
// master: the controlling side (drives en/delay/timeout, returns ready).
// slave:  the sequencer itself.
interface la_rstseq_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8,
  parameter int unsigned TW = 12
);
  import la_rstseq_pkg::*;

  localparam int unsigned SW = stage_width(N);

  logic            en;
  logic [N*CW-1:0] delay;
  logic [TW-1:0]   timeout;
  logic [N-1:0]    ready;
  logic [N-1:0]    nrst_out;
  logic            done;
  logic            busy;
  logic            err;
  logic [SW-1:0]   stage;

  modport master (
    output en, delay, timeout, ready,
    input  nrst_out, done, busy, err, stage
  );

  modport slave (
    input  en, delay, timeout, ready,
    output nrst_out, done, busy, err, stage
  );

endinterface

// File: rtl/la_dcounter.sv
// Loadable down counter with a zero flag; holds at zero.
module la_dcounter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         zero
);

  // Count register: load wins over decrement
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (dec && (q != '0)) begin
      q <= q - 1'b1;
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/la_rstseq.sv
// Reset-release sequencer for N downstream reset domains.
// Releases active-low domain resets in index order, each after its programmed
// delay and the previous domain's ready; asserts them in reverse order on shutdown.
// Optional ready-timeout supervision is built when LA_RSTSEQ_TIMEOUT_EN is defined.
module la_rstseq
  import la_rstseq_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned CW   = 8,
  parameter int unsigned TW   = 12,
  parameter              PROP = "DEFAULT"
) (
  input logic         clk,
  input logic         rst,
  la_rstseq_if.slave  bus
);

  localparam int unsigned SW = stage_width(N);
  localparam logic [SW-1:0] LastStage = SW'(N - 1);

  // PROP is a pass-through property with no functional effect
  localparam int unsigned unused_prop_bits = $bits(PROP);

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [N-1:0]  nrst_q, nrst_d;
  logic          done_q, done_d;

  logic          cnt_load, cnt_dec, cnt_zero;
  logic [SW-1:0] load_idx;
  logic [CW-1:0] load_val, cnt_q;

  // Delay fields are only looked at when a stage's count is loaded
  assign load_val = bus.delay[int'(load_idx)*CW +: CW];

  la_dcounter #(
    .W (CW)
  ) u_dcounter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (load_val),
    .q        (cnt_q),
    .zero     (cnt_zero)
  );

`ifdef LA_RSTSEQ_TIMEOUT_EN
  logic          err_q, err_d;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [TW-1:0] wcnt_inc;

  assign wcnt_inc = wcnt_q + 1'b1;
`else
  logic [TW-1:0] unused_timeout;
  assign unused_timeout = bus.timeout;
`endif

  // Next-state, next-output and counter control
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    nrst_d   = nrst_q;
    done_d   = done_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    load_idx = '0;
`ifdef LA_RSTSEQ_TIMEOUT_EN
    err_d    = err_q;
    wcnt_d   = wcnt_q;
    to_d     = to_q;
`endif
    unique case (state_q)
      StIdle: begin
        nrst_d = '0;
        if (bus.en) begin
          state_d  = StCount;
          stage_d  = '0;
          cnt_load = 1'b1;
        end
      end
      StCount: begin
        if (!bus.en) begin
          state_d = StIdle;
          stage_d = '0;
          nrst_d  = '0;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          nrst_d[stage_q] = 1'b1;
          state_d         = StWaitRdy;
`ifdef LA_RSTSEQ_TIMEOUT_EN
          wcnt_d = '0;
          to_d   = bus.timeout;
`endif
        end
      end
      StWaitRdy: begin
        if (!bus.en) begin
          state_d = StIdle;
          stage_d = '0;
          nrst_d  = '0;
        end else if (bus.ready[stage_q]) begin
          if (stage_q == LastStage) begin
            state_d = StUp;
            done_d  = 1'b1;
          end else begin
            state_d  = StCount;
            stage_d  = stage_q + 1'b1;
            cnt_load = 1'b1;
            load_idx = stage_q + 1'b1;
          end
        end
`ifdef LA_RSTSEQ_TIMEOUT_EN
        else begin
          wcnt_d = wcnt_inc;
          // timeout of zero disables the limit
          if ((to_q != '0) && (wcnt_inc == to_q)) begin
            state_d = StFail;
            err_d   = 1'b1;
            nrst_d  = '0;
          end
        end
`endif
      end
      StUp: begin
        if (!bus.en) begin
          state_d = StDown;
          stage_d = LastStage;
          done_d  = 1'b0;
        end
      end
      StDown: begin
        nrst_d[stage_q] = 1'b0;
        if (stage_q == '0) begin
          state_d = StIdle;
        end else begin
          stage_d = stage_q - 1'b1;
        end
      end
`ifdef LA_RSTSEQ_TIMEOUT_EN
      StFail: begin
        nrst_d = '0;
        if (!bus.en) begin
          state_d = StIdle;
          stage_d = '0;
          err_d   = 1'b0;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        stage_d = '0;
        nrst_d  = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; rst drops every domain immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      nrst_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      nrst_q  <= nrst_d;
      done_q  <= done_d;
    end
  end

`ifdef LA_RSTSEQ_TIMEOUT_EN
  // Ready-wait supervision registers
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      wcnt_q <= '0;
      to_q   <= '0;
    end else begin
      err_q  <= err_d;
      wcnt_q <= wcnt_d;
      to_q   <= to_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.nrst_out = nrst_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state_q == StCount) || (state_q == StWaitRdy) || (state_q == StDown);
  assign bus.stage    = stage_q;

endmodule

// File: tb/tb_la_rstseq.sv
// Directed self-checking bench for la_rstseq (N=4, CW=8, TW=12).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_la_rstseq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  la_rstseq_if #(.N(4), .CW(8), .TW(12)) bus ();

  la_rstseq #(
    .N    (4),
    .CW   (8),
    .TW   (12),
    .PROP ("DEFAULT")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.en      = 1'b0;
    bus.delay   = '0;
    bus.timeout = '0;
    bus.ready   = '0;

    // Reset state
    step(2);
    chk("rst_nrst", 32'(bus.nrst_out), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_stage", 32'(bus.stage), 32'h0);

    // Release timing: delays 2,0,1,0 for stages 0..3, all ready
    rst       = 1'b0;
    bus.delay = {8'd0, 8'd1, 8'd0, 8'd2};
    bus.ready = 4'hF;
    step(1);
    bus.en = 1'b1;
    step(1);  // E0: enter COUNT
    chk("e0_busy", 32'(bus.busy), 32'h1);
    chk("e0_nrst", 32'(bus.nrst_out), 32'h0);
    step(2);  // E2
    chk("e2_nrst", 32'(bus.nrst_out), 32'h0);
    step(1);  // E3
    chk("e3_nrst", 32'(bus.nrst_out), 32'h1);
    step(1);  // E4
    chk("e4_stage", 32'(bus.stage), 32'h1);
    chk("e4_nrst", 32'(bus.nrst_out), 32'h1);
    step(1);  // E5
    chk("e5_nrst", 32'(bus.nrst_out), 32'h3);
    step(2);  // E7
    chk("e7_nrst", 32'(bus.nrst_out), 32'h3);
    chk("e7_stage", 32'(bus.stage), 32'h2);
    step(1);  // E8
    chk("e8_nrst", 32'(bus.nrst_out), 32'h7);
    step(2);  // E10
    chk("e10_nrst", 32'(bus.nrst_out), 32'hF);
    chk("e10_done", 32'(bus.done), 32'h0);
    step(1);  // E11: UP
    chk("e11_done", 32'(bus.done), 32'h1);
    chk("e11_busy", 32'(bus.busy), 32'h0);
    bus.ready = 4'h0;  // ready drop in UP is ignored
    step(3);
    chk("up_hold_nrst", 32'(bus.nrst_out), 32'hF);
    chk("up_hold_done", 32'(bus.done), 32'h1);

    // Shutdown
    bus.en = 1'b0;
    step(1);
    chk("dn0_done", 32'(bus.done), 32'h0);
    chk("dn0_busy", 32'(bus.busy), 32'h1);
    chk("dn0_nrst", 32'(bus.nrst_out), 32'hF);
    step(1);
    chk("dn1_nrst", 32'(bus.nrst_out), 32'h7);
    step(1);
    chk("dn2_nrst", 32'(bus.nrst_out), 32'h3);
    step(1);
    chk("dn3_nrst", 32'(bus.nrst_out), 32'h1);
    step(1);
    chk("dn4_nrst", 32'(bus.nrst_out), 32'h0);
    chk("dn4_busy", 32'(bus.busy), 32'h0);

    // Ready gating: all delays 0, ready[1] held low
    bus.delay = '0;
    bus.ready = 4'b0001;
    bus.en    = 1'b1;
    step(4);  // E0 COUNT, E1 rel0, E2 COUNT s1, E3 rel1
    for (int i = 0; i < 10; i++) begin
      chk("gate_nrst", 32'(bus.nrst_out), 32'h3);
      chk("gate_stage", 32'(bus.stage), 32'h1);
      chk("gate_busy", 32'(bus.busy), 32'h1);
      step(1);
    end
    bus.ready = 4'b0011;
    step(1);
    chk("gate_s2", 32'(bus.stage), 32'h2);
    chk("gate_pre", 32'(bus.nrst_out), 32'h3);
    step(1);
    chk("gate_rel2", 32'(bus.nrst_out), 32'h7);

    // Abort while waiting on stage 2
    step(2);
    chk("abort_pre", 32'(bus.nrst_out), 32'h7);
    bus.en = 1'b0;
    step(1);
    chk("abort_nrst", 32'(bus.nrst_out), 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_stage", 32'(bus.stage), 32'h0);

    // Synchronous reset in the middle of a count
    bus.delay = {8'd0, 8'd0, 8'd0, 8'd10};
    bus.ready = 4'hF;
    bus.en    = 1'b1;
    step(4);
    chk("mid_busy", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    step(1);
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    chk("mrst_nrst", 32'(bus.nrst_out), 32'h0);
    chk("mrst_done", 32'(bus.done), 32'h0);
    rst    = 1'b0;
    bus.en = 1'b0;
    step(1);

    // Delay boundary: 0xFF releases 256 edges after COUNT entry; later edits ignored
    bus.delay = {8'd0, 8'd0, 8'd0, 8'hFF};
    bus.en    = 1'b1;
    step(1);  // COUNT entry
    bus.delay[7:0] = 8'h01;
    step(255);
    chk("ff_e255", 32'(bus.nrst_out), 32'h0);
    step(1);
    chk("ff_e256", 32'(bus.nrst_out), 32'h1);
    bus.en = 1'b0;
    step(1);
    chk("ff_abort", 32'(bus.nrst_out), 32'h0);

`ifdef LA_RSTSEQ_TIMEOUT_EN
    // Timeout of 5 with ready[0] low
    bus.delay   = '0;
    bus.ready   = 4'h0;
    bus.timeout = 12'd5;
    bus.en      = 1'b1;
    step(2);  // COUNT, then release 0 / WAIT entry
    chk("to_rel0", 32'(bus.nrst_out), 32'h1);
    step(4);
    chk("to_e4_err", 32'(bus.err), 32'h0);
    step(1);
    chk("to_err", 32'(bus.err), 32'h1);
    chk("to_nrst", 32'(bus.nrst_out), 32'h0);
    step(3);
    chk("to_sticky", 32'(bus.err), 32'h1);
    bus.en = 1'b0;
    step(1);
    chk("to_clr", 32'(bus.err), 32'h0);
    chk("to_idle", 32'(bus.busy), 32'h0);
`else
    // Without the timeout feature, waiting never errors
    bus.delay   = '0;
    bus.ready   = 4'h0;
    bus.timeout = 12'd5;
    bus.en      = 1'b1;
    step(1000);
    chk("nto_err", 32'(bus.err), 32'h0);
    chk("nto_nrst", 32'(bus.nrst_out), 32'h1);
    chk("nto_busy", 32'(bus.busy), 32'h1);
    bus.en = 1'b0;
    step(1);
    chk("nto_idle", 32'(bus.nrst_out), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
